// File: rtl/input_channel_buffer_pkg.sv
// input_channel_buffer_pkg: shared NoC constants used by input_channel_buffer and routing_unit.
// Contents: output channel IDs, destination field width, input-buffer FSM states and
// a helper that turns a channel ID into a one-hot switch request.
package input_channel_buffer_pkg;

    localparam int DEST_WIDTH   = 4;
    localparam int NUM_CHANNELS = 5;

    localparam logic [2:0] LOCAL = 3'd0;
    localparam logic [2:0] NORTH = 3'd1;
    localparam logic [2:0] SOUTH = 3'd2;
    localparam logic [2:0] EAST  = 3'd3;
    localparam logic [2:0] WEST  = 3'd4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ROUTE   = 2'd1,
        REQUEST = 2'd2
    } state_t;

    function automatic logic [NUM_CHANNELS-1:0] onehot(input logic [2:0] ch);
        return {{(NUM_CHANNELS-1){1'b0}}, 1'b1} << ch;
    endfunction

endpackage

// File: rtl/input_channel_buffer_channel_fifo.sv
// channel_fifo: circular packet store for one router input channel.
// Ports: clk, rst_n (sync, active low), push/wdata (ignored when full),
// pop (ignored when empty), head (oldest entry, 0 when empty), full, empty, count.
module channel_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   head,
    output logic                    full,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic                  do_push;
    logic                  do_pop;

    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
            count  <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/input_channel_buffer.sv
// input_channel_buffer: router input port that queues packets, asks the routing unit
// for an output channel and requests the switch arbiter until granted.
// Ports: clk, rst_n (sync, active low); data_in/valid_in/ready_out upstream link;
// dest_out/rout_in routing-unit handshake; req_out/grant_in arbiter handshake;
// data_out head packet to crossbar; route_err drop pulse; count_out occupancy.
module input_channel_buffer
    import input_channel_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_WIDTH-1:0]   data_in,
    input  logic                    valid_in,
    output logic                    ready_out,
    output logic [DEST_WIDTH-1:0]   dest_out,
    input  logic [2:0]              rout_in,
    output logic [NUM_CHANNELS-1:0] req_out,
    input  logic                    grant_in,
    output logic [DATA_WIDTH-1:0]   data_out,
    output logic                    route_err,
    output logic [$clog2(DEPTH):0]  count_out
);

    state_t     state;
    state_t     state_nx;
    logic [2:0] route_reg;
    logic [2:0] route_nx;
    logic       pop;
    logic       err_nx;
    logic       full;
    logic       empty;

    channel_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (valid_in),
        .pop   (pop),
        .wdata (data_in),
        .head  (data_out),
        .full  (full),
        .empty (empty),
        .count (count_out)
    );

    assign ready_out = !full;
    assign dest_out  = data_out[DEST_WIDTH-1:0];

    // Route IDs above WEST have no output port, so the head packet is dropped.
    always_comb begin
        state_nx = state;
        route_nx = route_reg;
        pop      = 1'b0;
        err_nx   = 1'b0;
        req_out  = '0;
        case (state)
            IDLE:    state_nx = empty ? IDLE : ROUTE;
            ROUTE: begin
                if (rout_in <= WEST) begin
                    route_nx = rout_in;
                    state_nx = REQUEST;
                end else begin
                    pop      = 1'b1;
                    err_nx   = 1'b1;
                    state_nx = IDLE;
                end
            end
            REQUEST: begin
                req_out  = onehot(route_reg);
                pop      = grant_in;
                state_nx = grant_in ? IDLE : REQUEST;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            route_reg <= '0;
            route_err <= 1'b0;
        end else begin
            state     <= state_nx;
            route_reg <= route_nx;
            route_err <= err_nx;
        end
    end

endmodule

// File: tb/tb_input_channel_buffer.sv
// tb_input_channel_buffer: self-checking bench for input_channel_buffer with an XY
// routing model for router 10 of a 4x4 mesh feeding rout_in.
module tb_input_channel_buffer;

    localparam int DW    = 8;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst_n;
    logic [DW-1:0] data_in;
    logic          valid_in;
    logic          ready_out;
    logic [3:0]    dest_out;
    logic [2:0]    rout_in;
    logic [4:0]    req_out;
    logic          grant_in;
    logic [DW-1:0] data_out;
    logic          route_err;
    logic [2:0]    count_out;

    logic          ovr_en;
    logic [2:0]    ovr_val;
    logic          chk_en;
    int            n_chk;
    int            n_fail;

    logic [7:0]    mq[$];
    int            phase;
    logic [2:0]    chan;
    logic          merr;
    logic [7:0]    rx[$];
    logic [4:0]    rq[$];

    input_channel_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .dest_out  (dest_out),
        .rout_in   (rout_in),
        .req_out   (req_out),
        .grant_in  (grant_in),
        .data_out  (data_out),
        .route_err (route_err),
        .count_out (count_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // XY routing for router 10 (x=2, y=2): 0 local, 1 north, 2 south, 3 east, 4 west.
    function automatic logic [2:0] xy_route(input logic [3:0] d);
        int dx, dy;
        dx = int'(d) % 4;
        dy = int'(d) / 4;
        if (dx > 2) return 3'd3;
        if (dx < 2) return 3'd4;
        if (dy > 2) return 3'd2;
        if (dy < 2) return 3'd1;
        return 3'd0;
    endfunction

    assign rout_in = ovr_en ? ovr_val : xy_route(dest_out);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Reference model: a packet queue plus the service step of the head packet
    // (0 waiting, 1 being routed, 2 requesting the switch).
    always @(posedge clk) begin : model
        logic       pm;
        logic       e;
        logic [2:0] r;
        if (!rst_n) begin
            mq.delete();
            phase = 0;
            chan  = 3'd0;
            merr  = 1'b0;
        end else begin
            pm = 1'b0;
            e  = 1'b0;
            r  = ovr_en ? ovr_val : xy_route(mq.size() > 0 ? mq[0][3:0] : 4'd0);
            if (phase == 0) begin
                if (mq.size() > 0) phase = 1;
            end else if (phase == 1) begin
                if (r <= 3'd4) begin
                    chan  = r;
                    phase = 2;
                end else begin
                    pm    = 1'b1;
                    e     = 1'b1;
                    phase = 0;
                end
            end else if (grant_in) begin
                pm    = 1'b1;
                phase = 0;
            end
            if (valid_in && mq.size() < DEPTH) begin
                if (pm) void'(mq.pop_front());
                mq.push_back(data_in);
            end else if (pm) begin
                void'(mq.pop_front());
            end
            merr = e;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", 32'(ready_out), 32'(mq.size() < DEPTH));
            chk("count", 32'(count_out), 32'(mq.size()));
            chk("dest", 32'(dest_out), mq.size() > 0 ? 32'(mq[0][3:0]) : 32'd0);
            chk("data", 32'(data_out), mq.size() > 0 ? 32'(mq[0]) : 32'd0);
            chk("req", 32'(req_out), phase == 2 ? 32'd1 << chan : 32'd0);
            chk("err", 32'(route_err), 32'(merr));
            if (req_out != 5'd0 && grant_in) begin
                rx.push_back(data_out);
                rq.push_back(req_out);
            end
        end
    end

    initial begin
        logic [4:0] exp_req [5];
        logic [7:0] pk36    [5];
        logic       r;
        int         i;
        int         guard;
        exp_req = '{5'b01000, 5'b00100, 5'b10000, 5'b00010, 5'b00001};
        pk36    = '{8'h1B, 8'h2E, 8'h38, 8'h42, 8'h5A};
        n_chk = 0; n_fail = 0; chk_en = 1'b0;
        rst_n = 1'b0; valid_in = 1'b0; grant_in = 1'b0; data_in = '0;
        ovr_en = 1'b0; ovr_val = 3'd0;
        tick(); tick();
        rst_n = 1'b1; chk_en = 1'b1;
        chk("rst_ready", 32'(ready_out), 32'd1);
        chk("rst_count", 32'(count_out), 32'd0);
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_req", 32'(req_out), 32'd0);

        // single packet latency and delivery
        data_in = 8'hAB; valid_in = 1'b1; tick(); valid_in = 1'b0;
        chk("lat_n0_req", 32'(req_out), 32'd0);
        tick();
        chk("lat_n1_req", 32'(req_out), 32'd0);
        tick();
        chk("lat_n2_req", 32'(req_out), 32'b01000);
        chk("lat_head", 32'(data_out), 32'hAB);
        grant_in = 1'b1; tick(); grant_in = 1'b0;
        chk("lat_count", 32'(count_out), 32'd0);
        chk("lat_rx", rx.size() > 0 ? 32'(rx[rx.size()-1]) : 32'hFFFF, 32'hAB);

        // fill to full, ignored fifth push, one grant frees a slot
        valid_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            data_in = 8'(8'h30 + k);
            tick();
        end
        chk("full_count", 32'(count_out), 32'd4);
        chk("full_ready", 32'(ready_out), 32'd0);
        data_in = 8'h55; tick(); valid_in = 1'b0;
        chk("full_ign_count", 32'(count_out), 32'd4);
        chk("full_ign_head", 32'(data_out), 32'h30);
        grant_in = 1'b1; tick(); grant_in = 1'b0;
        chk("full_grant_count", 32'(count_out), 32'd3);
        chk("full_grant_ready", 32'(ready_out), 32'd1);
        chk("full_grant_head", 32'(data_out), 32'h31);
        grant_in = 1'b1; repeat (12) tick(); grant_in = 1'b0;
        chk("full_drain", 32'(count_out), 32'd0);

        // request sequence for five destinations
        rq.delete();
        grant_in = 1'b1;
        valid_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            data_in = pk36[k];
            tick();
        end
        valid_in = 1'b0;
        repeat (20) tick();
        grant_in = 1'b0;
        chk("seq_n", 32'(rq.size()), 32'd5);
        for (int k = 0; k < 5; k++)
            chk($sformatf("seq_req%0d", k), rq.size() > k ? 32'(rq[k]) : 32'hFFFF, 32'(exp_req[k]));

        // illegal route drops packets
        ovr_en = 1'b1; ovr_val = 3'd7;
        valid_in = 1'b1; data_in = 8'h77; tick();
        data_in = 8'h78; tick(); valid_in = 1'b0;
        chk("drop_pre_err", 32'(route_err), 32'd0);
        tick();
        chk("drop_err", 32'(route_err), 32'd1);
        chk("drop_count", 32'(count_out), 32'd1);
        chk("drop_req", 32'(req_out), 32'd0);
        chk("drop_head", 32'(data_out), 32'h78);
        tick();
        chk("drop_err_clr", 32'(route_err), 32'd0);
        repeat (4) tick();
        ovr_en = 1'b0;
        chk("drop_all", 32'(count_out), 32'd0);

        // reset while requesting with three stored packets
        valid_in = 1'b1;
        for (int k = 0; k < 3; k++) begin
            data_in = 8'(8'h91 + k);
            tick();
        end
        valid_in = 1'b0;
        tick();
        chk("prerst_req", 32'(req_out), 32'b10000);
        chk("prerst_count", 32'(count_out), 32'd3);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("midrst_count", 32'(count_out), 32'd0);
        chk("midrst_req", 32'(req_out), 32'd0);
        chk("midrst_ready", 32'(ready_out), 32'd1);
        chk("midrst_data", 32'(data_out), 32'd0);
        tick();
        chk("midrst_idle", 32'(req_out), 32'd0);

        // continuous traffic across pointer wrap
        rx.delete();
        grant_in = 1'b1; valid_in = 1'b1;
        i = 0; guard = 0;
        while (i < 12 && guard < 200) begin
            data_in = 8'(8'h60 + i);
            r = ready_out;
            tick();
            if (r) i++;
            guard++;
        end
        valid_in = 1'b0;
        chk("wrap_pushed", 32'(i), 32'd12);
        repeat (20) tick();
        grant_in = 1'b0;
        chk("wrap_n", 32'(rx.size()), 32'd12);
        for (int k = 0; k < 12; k++)
            chk($sformatf("wrap_rx%0d", k), rx.size() > k ? 32'(rx[k]) : 32'hFFFF, 32'(8'h60 + k));
        chk("wrap_count", 32'(count_out), 32'd0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/input_channel_buffer.md
INPUT_CHANNEL_BUFFER -- requirements
Module: input_channel_buffer

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, meaning the packet width in bits; destination router ID = data bits [3:0]; legal range 8 and up.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the number of FIFO entries; power of two, 2 and up.
REQ-003 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit, meaning a synchronous active-low reset.
REQ-005 The block SHALL have port data_in, input, DATA_WIDTH bits, meaning the packet from the upstream link.
REQ-006 The block SHALL have port valid_in, input, 1 bit, meaning data_in is valid.
REQ-007 The block SHALL have port ready_out, output, 1 bit, meaning the buffer can accept a packet.
REQ-008 The block SHALL have port dest_out, output, 4 bits, meaning the head-packet destination ID, driven to the routing unit.
REQ-009 The block SHALL have port rout_in, input, 3 bits, meaning the channel ID returned by the routing unit (0 local, 1 north, 2 south, 3 east, 4 west).
REQ-010 The block SHALL have port req_out, output, 5 bits, meaning a one-hot output-channel request to the switch arbiter, with bit index = channel ID.
REQ-011 The block SHALL have port grant_in, input, 1 bit, meaning the arbiter grants the pending request.
REQ-012 The block SHALL have port data_out, output, DATA_WIDTH bits, meaning the head packet toward the crossbar.
REQ-013 The block SHALL have port route_err, output, 1 bit, meaning a one-cycle pulse when a packet is dropped for an illegal route.
REQ-014 The block SHALL have port count_out, output, log2(DEPTH)+1 bits, meaning the current occupancy.

Function
REQ-015 A push SHALL occur on a rising edge when valid_in=1 and ready_out=1; ready_out SHALL equal (count < DEPTH) and SHALL not depend on a same-cycle pop.
REQ-016 A push with valid_in=1 while full SHALL be ignored; no entry, pointer or count SHALL change.
REQ-017 dest_out and data_out SHALL reflect the head entry combinationally; both SHALL be 0 when the FIFO is empty.
REQ-018 The FSM SHALL have states IDLE, ROUTE and REQUEST, and SHALL reset to IDLE.
REQ-019 In IDLE, if count>0 the next state SHALL be ROUTE; otherwise the FSM SHALL remain in IDLE.
REQ-020 In ROUTE, if rout_in is 0..4 the block SHALL register rout_in into route_reg and go to REQUEST.
REQ-021 In ROUTE, if rout_in is 5..7 the block SHALL pop the head, pulse route_err for one cycle and go to IDLE.
REQ-022 In REQUEST, req_out SHALL be onehot(route_reg); in all other states req_out SHALL be 0.
REQ-023 In REQUEST, on an edge with grant_in=1 the block SHALL pop the head, the consumer SHALL sample data_out on that same edge, and the FSM SHALL go to IDLE.
REQ-024 In REQUEST without grant_in, the FSM and the head entry SHALL hold indefinitely.
REQ-025 grant_in SHALL be ignored outside REQUEST.
REQ-026 Latency: a packet written into an empty buffer at edge N SHALL enter ROUTE at edge N+1 and assert req_out from edge N+2; the minimum per-packet service time SHALL be 3 cycles.
REQ-027 A simultaneous push and pop SHALL leave count unchanged; both pointers SHALL advance and wrap modulo DEPTH.
REQ-028 count SHALL never exceed DEPTH or go below 0.

Reset
REQ-029 When rst_n=0 at a rising edge, the block SHALL clear the pointers, count and route_reg, set the state to IDLE and set req_out=0 and route_err=0.
REQ-030 A reset mid-operation SHALL discard all stored packets, including a pending request.
REQ-031 After reset, ready_out SHALL be 1, count_out SHALL be 0, and dest_out and data_out SHALL be 0.

Structure
REQ-032 The channel IDs (LOCAL=0, NORTH=1, SOUTH=2, EAST=3, WEST=4), DEST_WIDTH=4 and the FSM state encodings SHALL reside in the shared NoC parameter include, used jointly with routing_unit.
REQ-033 Storage SHALL be a sub-module channel_fifo (push, pop, full, empty, head, count); the FSM and request logic SHALL live in input_channel_buffer.

Verification
REQ-034 With rout_in driven by routing_unit with ROUTER_ID=10, pushing packet 8'hAB (dest 11) SHALL give req_out=5'b01000 at the 2nd edge after the push; holding grant_in=1 for one edge SHALL give data_out=8'hAB sampled and count returning to 0.
REQ-035 Pushing 4 packets with no grant SHALL give ready_out=0 and count_out=4; a 5th push SHALL be ignored; one grant SHALL restore ready_out=1.
REQ-036 Pushing packets with dests 11, 14, 8, 2 and 10 with grants always high SHALL give req_out 01000, 00100, 10000, 00010 and 00001 in order.
REQ-037 Forcing rout_in=3'b111 in ROUTE SHALL produce a one-cycle route_err pulse, drop the packet, keep req_out=0 and decrement count by 1.
REQ-038 Asserting rst_n=0 for one edge while in REQUEST with 3 stored packets SHALL give count_out=0, req_out=0, the state IDLE and ready_out=1 on the next cycle.
REQ-039 Holding valid_in=1 and grant_in=1 continuously SHALL demonstrate pointer wrap over more than 8 packets, with in-order delivery and no loss.
